// File: rtl/decoder_scan_ctrl.sv
// Sequencer for a 2:4 decoder with active-low enable and active-low outputs.
// Steps through channels 0..3 in ascending order. Each channel gets a blanking
// window (en_n high, address settles), then a dwell window (en_n low).
// Supports single-sweep or continuous runs, a per-channel skip mask and a
// stop request that lets the current channel finish.
module decoder_scan_ctrl #(
    parameter int DWELL = 4,  // cycles en_n is low per channel, 1..2**CNT_W
    parameter int BLANK = 1,  // cycles en_n is high before each dwell, 1..2**CNT_W
    parameter int CNT_W = 8   // phase counter width
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run_mode,
    input  logic       stop,
    input  logic [3:0] mask,
    output logic       en_n,
    output logic       a,
    output logic       b,
    output logic [1:0] chan,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DWELL,
        S_DONE
    } state_t;

    // The counter runs 0..N-1 in each phase, so the terminal value is N-1.
    localparam logic [CNT_W-1:0] L_BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [CNT_W-1:0] L_DWELL_LAST = CNT_W'(DWELL - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [1:0]       r_chan,  w_chan_nxt;
    logic [3:0]       r_mask,  w_mask_nxt;
    logic             r_mode,  w_mode_nxt;
    logic             r_stop,  w_stop_nxt;
    logic             r_en_n;
    logic             r_busy;
    logic             r_done;

    logic [2:0]       w_first_ch;  // {found, channel}: lowest unmasked channel of the incoming mask
    logic [2:0]       w_next_ch;   // {found, channel}: channel after the current one for this run
    logic             w_stop_eff;  // stop requested either earlier in the run or in this cycle

    // Lowest unmasked channel. The MSB flags that one exists.
    function automatic logic [2:0] f_lowest(input logic [3:0] m);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (!m[i]) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    // Next higher unmasked channel. With wrap set it falls back to the lowest
    // unmasked one, which can be the current channel itself.
    function automatic logic [2:0] f_after(input logic [1:0] cur, input logic [3:0] m,
                                           input logic wrap);
        logic [2:0] res;
        res = wrap ? f_lowest(m) : 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(cur) && !m[i]) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    // Next-state logic: phase sequencing, channel stepping and the stop latch.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_chan_nxt  = r_chan;
        w_mask_nxt  = r_mask;
        w_mode_nxt  = r_mode;
        w_stop_nxt  = r_stop | (r_busy & stop);
        w_first_ch  = f_lowest(mask);
        w_next_ch   = f_after(r_chan, r_mask, r_mode);
        w_stop_eff  = r_stop | stop;

        case (r_state)
            S_IDLE: begin
                w_stop_nxt = 1'b0;
                w_cnt_nxt  = '0;
                if (start) begin
                    w_mask_nxt = mask;
                    w_mode_nxt = run_mode;
                    if (w_first_ch[2]) begin
                        w_state_nxt = S_BLANK;
                        w_chan_nxt  = w_first_ch[1:0];
                    end else begin
                        // Every channel is masked. Finish at once without ever enabling the decoder.
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_BLANK: begin
                if (r_cnt == L_BLANK_LAST) begin
                    w_state_nxt = S_DWELL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DWELL: begin
                if (r_cnt == L_DWELL_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_stop_eff || !w_next_ch[2]) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        // The address only moves on entry to BLANK, so en_n is high whenever {a,b} changes.
                        w_state_nxt = S_BLANK;
                        w_chan_nxt  = w_next_ch[1:0];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register. Outputs are registered and derived from the next state.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register update from the same pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_chan  <= 2'b00;
            r_mask  <= 4'h0;
            r_mode  <= 1'b0;
            r_stop  <= 1'b0;
            r_en_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chan  <= w_chan_nxt;
            r_mask  <= w_mask_nxt;
            r_mode  <= w_mode_nxt;
            r_stop  <= w_stop_nxt;
            r_en_n  <= (w_state_nxt != S_DWELL);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    assign en_n = r_en_n;
    assign a    = r_chan[1];
    assign b    = r_chan[0];
    assign chan = r_chan;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl. Each scenario builds the expected
// per-cycle output trace from the list of channels it should visit, then
// compares that trace cycle by cycle against the DUT.
module tb_decoder_scan_ctrl;

    localparam int DWELL = 4;
    localparam int BLANK = 1;
    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       run_mode;
    logic       stop;
    logic [3:0] mask;
    logic       en_n;
    logic       a;
    logic       b;
    logic [1:0] chan;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic       en_n;
        logic [1:0] chan;
        logic       busy;
        logic       done;
    } obs_t;

    obs_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [1:0] last_chan;
    logic [3:0] y_tab [4];

    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DWELL(DWELL), .BLANK(BLANK), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .run_mode (run_mode),
        .stop     (stop),
        .mask     (mask),
        .en_n     (en_n),
        .a        (a),
        .b        (b),
        .chan     (chan),
        .busy     (busy),
        .done     (done)
    );

    // Gate-level 2:4 decoder with active-low enable and active-low outputs, driven by the DUT.
    function automatic logic [3:0] decode_y(input logic en_n_i, input logic [1:0] sel);
        logic [3:0] y;
        for (int i = 0; i < 4; i++) y[i] = en_n_i | (sel != 2'(i));
        return y;
    endfunction

    task automatic push_channel(input logic [1:0] ch);
        for (int i = 0; i < BLANK; i++) exp_q.push_back(obs_t'{1'b1, ch, 1'b1, 1'b0});
        for (int i = 0; i < DWELL; i++) exp_q.push_back(obs_t'{1'b0, ch, 1'b1, 1'b0});
        last_chan = ch;
    endtask

    task automatic push_done();
        exp_q.push_back(obs_t'{1'b1, last_chan, 1'b1, 1'b1});
        exp_q.push_back(obs_t'{1'b1, last_chan, 1'b0, 1'b0});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(obs_t'{1'b1, last_chan, 1'b0, 1'b0});
    endtask

    // Pops one expected entry per clock and compares it against the DUT.
    // After the comparison in cycle k it can pulse stop, assert rst for two
    // edges, or pulse start with a different mask while the run is busy.
    task automatic drain(input string name, input int stop_cyc, input int rst_cyc,
                         input int start_cyc);
        obs_t expv;
        obs_t obs;
        int   k;
        k = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            k++;
            start = 1'b0;
            stop  = 1'b0;
            expv  = exp_q.pop_front();
            obs   = {en_n, chan, busy, done};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL %s c%0d: got en_n=%b chan=%0d busy=%b done=%b, want en_n=%b chan=%0d busy=%b done=%b",
                         name, k, obs.en_n, obs.chan, obs.busy, obs.done,
                         expv.en_n, expv.chan, expv.busy, expv.done);
            end
            total++;
            if (chan !== {a, b}) begin
                bad++;
                $display("FAIL %s_chan_ab c%0d: got chan=%0d {a,b}=%b%b, want equal", name, k, chan, a, b);
            end
            if (expv.en_n == 1'b0) begin
                total++;
                if (decode_y(en_n, {a, b}) !== y_tab[expv.chan]) begin
                    bad++;
                    $display("FAIL %s_y c%0d: got y=%b, want y=%b", name, k,
                             decode_y(en_n, {a, b}), y_tab[expv.chan]);
                end
            end
            if (k == stop_cyc) stop = 1'b1;
            if (k == rst_cyc) rst = 1'b1;
            if (k == rst_cyc + 2) rst = 1'b0;
            if (k == start_cyc) begin
                start    = 1'b1;
                mask     = 4'hF;
                run_mode = 1'b1;
            end
        end
    endtask

    task automatic begin_run(input logic mode, input logic [3:0] m);
        run_mode = mode;
        mask     = m;
        start    = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        run_mode = 1'b0;
        mask     = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({en_n, a, b, chan, busy, done} !== 7'b1_0_0_00_0_0) begin
            bad++;
            $display("FAIL reset_values: got en_n=%b a=%b b=%b chan=%0d busy=%b done=%b, want 1 0 0 0 0 0",
                     en_n, a, b, chan, busy, done);
        end
        rst       = 1'b0;
        last_chan = 2'd0;
        // Idle hold, with a stray stop pulse that must not matter in IDLE.
        push_idle(5);
        drain("reset_idle", 2, -10, -1);
    endtask

    task automatic test_single_sweep();
        begin_run(1'b0, 4'b0000);
        for (int c = 0; c < 4; c++) push_channel(2'(c));
        push_done();
        drain("single_sweep", -1, -10, -1);
    endtask

    task automatic test_masked_sweep();
        begin_run(1'b0, 4'b0101);
        push_channel(2'd1);
        push_channel(2'd3);
        push_done();
        drain("masked_sweep", -1, -10, -1);
    endtask

    // Continuous run wraps 3 -> 0; stop in the second visit to ch1, dwell cycle 2 (c28).
    task automatic test_continuous_stop();
        begin_run(1'b1, 4'b0000);
        for (int c = 0; c < 4; c++) push_channel(2'(c));
        push_channel(2'd0);
        push_channel(2'd1);
        push_done();
        drain("continuous_stop", 28, -10, -1);
    endtask

    // Continuous with one unmasked channel repeats it until stopped.
    task automatic test_single_channel_repeat();
        begin_run(1'b1, 4'b1011);
        push_channel(2'd2);
        push_channel(2'd2);
        push_channel(2'd2);
        push_done();
        drain("repeat_ch2", 12, -10, -1);
    endtask

    task automatic test_all_masked();
        begin_run(1'b0, 4'hF);
        push_done();
        drain("all_masked", -1, -10, -1);
    endtask

    // rst raised during ch2 dwell cycle 2 (c13); outputs return to reset values with no done pulse.
    task automatic test_reset_midrun();
        begin_run(1'b0, 4'b0000);
        push_channel(2'd0);
        push_channel(2'd1);
        exp_q.push_back(obs_t'{1'b1, 2'd2, 1'b1, 1'b0});
        exp_q.push_back(obs_t'{1'b0, 2'd2, 1'b1, 1'b0});
        exp_q.push_back(obs_t'{1'b0, 2'd2, 1'b1, 1'b0});
        last_chan = 2'd0;
        push_idle(4);
        drain("reset_midrun", -1, 13, -1);
    endtask

    // A start pulse with a new mask and mode in the middle of a run is ignored.
    task automatic test_back_to_back();
        begin_run(1'b0, 4'b0000);
        for (int c = 0; c < 4; c++) push_channel(2'(c));
        push_done();
        drain("start_while_busy", -1, -10, 8);
    endtask

    initial begin
        y_tab[0] = 4'b1110;
        y_tab[1] = 4'b1101;
        y_tab[2] = 4'b1011;
        y_tab[3] = 4'b0111;
        test_reset();
        test_single_sweep();
        test_masked_sweep();
        test_continuous_stop();
        test_all_masked();
        test_single_channel_repeat();
        test_reset_midrun();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
